// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO of {pc, insn} with first-word fall-through, 1-cycle min latency.
// Flush (branch redirect) drops all wrong-path entries; fetch_ready depends only on registered count.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_pc,
  input  logic [31:0]              fetch_insn,
  output logic                     fetch_ready,
  input  logic                     flush,
  output logic                     decode_valid,
  output logic [31:0]              decode_pc,
  output logic [31:0]              decode_insn,
  input  logic                     decode_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   r_pc   [DEPTH];
  logic [31:0]   r_insn [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_enq;
  logic w_deq;
  logic w_ready;
  logic w_valid;

  assign w_ready = (r_count != FULL_CNT);
  assign w_valid = (r_count != '0);
  assign w_enq   = fetch_valid & w_ready;
  assign w_deq   = w_valid & decode_ready;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_enq && !w_deq)      r_count <= r_count + CW'(1);
      else if (w_deq && !w_enq) r_count <= r_count - CW'(1);
    end
  end

  // Storage has no reset; a write during flush/reset is suppressed so the redirect cycle leaves no trace.
  always_ff @(posedge clock) begin
    if (w_enq && !flush && !reset) begin
      r_pc[r_wr_ptr]   <= fetch_pc;
      r_insn[r_wr_ptr] <= fetch_insn;
    end
  end

  assign fetch_ready  = w_ready;
  assign decode_valid = w_valid;
  assign decode_pc    = w_valid ? r_pc[r_rd_ptr]   : 32'h0;
  assign decode_insn  = w_valid ? r_insn[r_rd_ptr] : NOP_INSN;
  assign count        = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill, full+dequeue, drain, streaming wrap, flush, mid-stream reset.
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_insn;
  logic        fetch_ready;
  logic        flush;
  logic        decode_valid;
  logic [31:0] decode_pc;
  logic [31:0] decode_insn;
  logic        decode_ready;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_queue #(.DEPTH(4), .NOP_INSN(32'h00000013)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_insn  (fetch_insn),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .decode_valid(decode_valid),
    .decode_pc   (decode_pc),
    .decode_insn (decode_insn),
    .decode_ready(decode_ready),
    .count       (count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    return pc ^ 32'hA5A50000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_insn  = insn_of(pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; decode_ready = 1'b0;
    offer(32'hDEAD0000);
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dvalid", 32'(decode_valid), 32'd0);
    chk("rst_insn", decode_insn, 32'h00000013);
    chk("rst_pc", decode_pc, 32'h0);
    chk("rst_fready", 32'(fetch_ready), 32'd1);
    fetch_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("rst_hold_count", 32'(count), 32'd0);

    // Fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      offer(32'h01000000 + 32'(4 * i));
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_head_pc", decode_pc, 32'h01000000);
      chk("fill_head_insn", decode_insn, insn_of(32'h01000000));
    end
    chk("full_fready", 32'(fetch_ready), 32'd0);
    offer(32'h01000010);
    tick();
    chk("full_reject_count", 32'(count), 32'd4);
    chk("full_head_pc", decode_pc, 32'h01000000);

    // Full with dequeue: deq only, then pending entry accepted
    decode_ready = 1'b1;
    tick();
    chk("fulldeq_count", 32'(count), 32'd3);
    chk("fulldeq_head", decode_pc, 32'h01000004);
    decode_ready = 1'b0;
    tick();
    chk("fulldeq_accept_count", 32'(count), 32'd4);
    fetch_valid = 1'b0;

    // Drain in order
    decode_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", decode_pc, 32'h01000004 + 32'(4 * i));
      chk("drain_insn", decode_insn, insn_of(32'h01000004 + 32'(4 * i)));
      tick();
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_dvalid", 32'(decode_valid), 32'd0);
    chk("drain_nop", decode_insn, 32'h00000013);
    chk("drain_pc0", decode_pc, 32'h0);

    // Streaming across pointer wrap
    for (int k = 0; k < 10; k++) begin
      offer(32'h02000000 + 32'(4 * k));
      if (k == 0) begin
        chk("stream_empty_dvalid", 32'(decode_valid), 32'd0);
      end else begin
        chk("stream_pc", decode_pc, 32'h02000000 + 32'(4 * (k - 1)));
        chk("stream_count", 32'(count), 32'd1);
      end
      tick();
    end
    fetch_valid = 1'b0;
    chk("stream_last_pc", decode_pc, 32'h02000024);
    chk("stream_last_insn", decode_insn, insn_of(32'h02000024));
    tick();
    chk("stream_end_count", 32'(count), 32'd0);

    // Flush with concurrent enq/deq requests
    decode_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h01000020 + 32'(4 * i));
      tick();
    end
    chk("preflush_count", 32'(count), 32'd3);
    offer(32'h01000040);
    decode_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch_valid = 1'b0;
    decode_ready = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_dvalid", 32'(decode_valid), 32'd0);
    chk("flush_fready", 32'(fetch_ready), 32'd1);
    chk("flush_nop", decode_insn, 32'h00000013);
    offer(32'h01000080);
    tick();
    fetch_valid = 1'b0;
    chk("redirect_dvalid", 32'(decode_valid), 32'd1);
    chk("redirect_pc", decode_pc, 32'h01000080);
    chk("redirect_count", 32'(count), 32'd1);

    // Reset mid-stream
    offer(32'h01000084);
    tick();
    fetch_valid = 1'b0;
    chk("mid_count", 32'(count), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_dvalid", 32'(decode_valid), 32'd0);
    chk("midrst_insn", decode_insn, 32'h00000013);
    chk("midrst_pc", decode_pc, 32'h0);
    chk("midrst_fready", 32'(fetch_ready), 32'd1);
    decode_ready = 1'b1;
    tick(); tick();
    chk("midrst_stale_dvalid", 32'(decode_valid), 32'd0);
    offer(32'h03000000);
    decode_ready = 1'b0;
    tick();
    fetch_valid = 1'b0;
    chk("postrst_pc", decode_pc, 32'h03000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
